// File: rtl/coprocessador_matricial.sv
// Streaming matrix coprocessor: add, subtract, scalar multiply, negate and transpose on NxN signed matrices.
// Define COPROC_MULT_MATRIZ_EN to also build the matrix product (opcode 010) with a one-MAC-per-cycle datapath.
module coprocessador_matricial #(
    parameter int DATA_W = 8,
    parameter int MAX_N  = 5,
    parameter int RES_W  = 2*DATA_W+3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       iniciar,
    input  logic [2:0]                 operacao,
    input  logic [$clog2(MAX_N+1)-1:0] tamanho,
    input  logic [DATA_W-1:0]          entrada_dado,
    input  logic                       entrada_valida,
    output logic                       entrada_pronta,
    output logic [RES_W-1:0]           saida_dado,
    output logic                       saida_valida,
    input  logic                       saida_pronta,
    output logic                       saida_ultimo,
    output logic                       ocupado,
    output logic                       erro
);
    localparam int TAM_W  = $clog2(MAX_N+1);
    localparam int NELEM  = MAX_N*MAX_N;
    localparam int ADDR_W = (NELEM > 1) ? $clog2(NELEM) : 1;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b010;
    localparam logic [2:0] OP_SCALE = 3'b011;
    localparam logic [2:0] OP_NEG   = 3'b100;
    localparam logic [2:0] OP_TRANS = 3'b101;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CARGA_A = 3'd1,
        CARGA_B = 3'd2,
        CALCULO = 3'd3,
        SAIDA   = 3'd4
    } estado_t;

    // Storage uses a fixed MAX_N row stride so addressing never depends on the runtime size.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [TAM_W-1:0] r, input logic [TAM_W-1:0] c);
        return ADDR_W'(int'(r) * MAX_N + int'(c));
    endfunction

    function automatic logic signed [RES_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{(RES_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    function automatic logic op_valid(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SCALE, OP_NEG, OP_TRANS: op_valid = 1'b1;
`ifdef COPROC_MULT_MATRIZ_EN
            OP_MUL:                                     op_valid = 1'b1;
`endif
            default:                                    op_valid = 1'b0;
        endcase
    endfunction

    estado_t                 state_r, state_s;
    logic [2:0]              op_r;
    logic [TAM_W-1:0]        n_r, row_r, col_r, next_row_s, next_col_s;
    logic [DATA_W-1:0]       k_r;
    logic [DATA_W-1:0]       mat_a [NELEM];
    logic [DATA_W-1:0]       mat_b [NELEM];
    logic [RES_W-1:0]        mat_r [NELEM];
    logic [ADDR_W-1:0]       addr_s, addr_t_s, out_addr_s;
    logic signed [RES_W-1:0] res_s;
    logic [RES_W-1:0]        out_val_s;
    logic                    last_col_s, last_row_s, last_elem_s, next_last_s;
    logic                    in_xfer_s, out_xfer_s, cmd_ok_s, adv_s, step_s, wr_en_s, load_out_s;
`ifdef COPROC_MULT_MATRIZ_EN
    logic [TAM_W-1:0]        kk_r;
    logic signed [RES_W-1:0] acc_r;
    logic                    kk_last_s;
`endif

    assign last_col_s  = (col_r == n_r - TAM_W'(1));
    assign last_row_s  = (row_r == n_r - TAM_W'(1));
    assign last_elem_s = last_col_s && last_row_s;
    assign in_xfer_s   = entrada_valida && entrada_pronta;
    assign out_xfer_s  = saida_valida && saida_pronta;
    assign cmd_ok_s    = (tamanho != {TAM_W{1'b0}}) && (tamanho <= TAM_W'(MAX_N)) && op_valid(operacao);
    assign addr_s      = addr_of(row_r, col_r);
    assign addr_t_s    = addr_of(col_r, row_r);
    assign out_addr_s  = addr_of(next_row_s, next_col_s);
    assign next_last_s = (next_row_s == n_r - TAM_W'(1)) && (next_col_s == n_r - TAM_W'(1));
    assign wr_en_s     = (state_r == CALCULO) && adv_s;
    assign load_out_s  = (state_s == SAIDA) && ((state_r != SAIDA) || out_xfer_s);
`ifdef COPROC_MULT_MATRIZ_EN
    assign kk_last_s   = (kk_r == n_r - TAM_W'(1));
    assign adv_s       = (op_r != OP_MUL) || kk_last_s;
`else
    assign adv_s       = 1'b1;
`endif

    // Row-major successor of the current (row, col), wrapping to (0, 0) after the last element
    always_comb begin
        next_row_s = row_r;
        next_col_s = col_r;
        if (last_col_s) begin
            next_col_s = {TAM_W{1'b0}};
            if (last_row_s) begin
                next_row_s = {TAM_W{1'b0}};
            end else begin
                next_row_s = row_r + TAM_W'(1);
            end
        end else begin
            next_col_s = col_r + TAM_W'(1);
        end
    end

    // When the row/col walker advances in each state
    always_comb begin
        step_s = 1'b0;
        case (state_r)
            CARGA_A: step_s = in_xfer_s;
            CARGA_B: step_s = in_xfer_s && (op_r != OP_SCALE);
            CALCULO: step_s = adv_s;
            SAIDA:   step_s = out_xfer_s;
            default: step_s = 1'b0;
        endcase
    end

    // Result datapath for the element at (row, col)
    always_comb begin
        res_s = {RES_W{1'b0}};
        case (op_r)
            OP_ADD:   res_s = sext(mat_a[addr_s]) + sext(mat_b[addr_s]);
            OP_SUB:   res_s = sext(mat_a[addr_s]) - sext(mat_b[addr_s]);
            OP_SCALE: res_s = sext(mat_a[addr_s]) * sext(k_r);
            OP_NEG:   res_s = -sext(mat_a[addr_s]);
            OP_TRANS: res_s = sext(mat_a[addr_t_s]);
`ifdef COPROC_MULT_MATRIZ_EN
            OP_MUL:   res_s = acc_r + sext(mat_a[addr_of(row_r, kk_r)]) * sext(mat_b[addr_of(kk_r, col_r)]);
`endif
            default:  res_s = {RES_W{1'b0}};
        endcase
    end

    // Forward the result being written when it is the very element about to be presented (N = 1)
    always_comb begin
        if (wr_en_s && (addr_s == out_addr_s)) begin
            out_val_s = res_s;
        end else begin
            out_val_s = mat_r[out_addr_s];
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (iniciar && cmd_ok_s) state_s = CARGA_A;
                else                     state_s = IDLE;
            end
            CARGA_A: begin
                if (in_xfer_s && last_elem_s) begin
                    if (op_r == OP_ADD || op_r == OP_SUB || op_r == OP_MUL || op_r == OP_SCALE) state_s = CARGA_B;
                    else                                                                      state_s = CALCULO;
                end else begin
                    state_s = CARGA_A;
                end
            end
            CARGA_B: begin
                if (in_xfer_s && (op_r == OP_SCALE || last_elem_s)) state_s = CALCULO;
                else                                                state_s = CARGA_B;
            end
            CALCULO: begin
                if (adv_s && last_elem_s) state_s = SAIDA;
                else                      state_s = CALCULO;
            end
            SAIDA: begin
                if (out_xfer_s && saida_ultimo) state_s = IDLE;
                else                            state_s = SAIDA;
            end
            default: state_s = IDLE;
        endcase
    end

    // Matrix storage; contents survive reset and are simply overwritten by the next command
    always_ff @(posedge clk) begin
        if (state_r == CARGA_A && in_xfer_s) begin
            mat_a[addr_s] <= entrada_dado;
        end
        if (state_r == CARGA_B && in_xfer_s) begin
            if (op_r == OP_SCALE) k_r <= entrada_dado;
            else                  mat_b[addr_s] <= entrada_dado;
        end
        if (wr_en_s) begin
            mat_r[addr_s] <= res_s;
        end
    end

    // Control state, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            op_r           <= 3'b000;
            n_r            <= {TAM_W{1'b0}};
            row_r          <= {TAM_W{1'b0}};
            col_r          <= {TAM_W{1'b0}};
            entrada_pronta <= 1'b0;
            saida_dado     <= {RES_W{1'b0}};
            saida_valida   <= 1'b0;
            saida_ultimo   <= 1'b0;
            ocupado        <= 1'b0;
            erro           <= 1'b0;
`ifdef COPROC_MULT_MATRIZ_EN
            kk_r           <= {TAM_W{1'b0}};
            acc_r          <= {RES_W{1'b0}};
`endif
        end else begin
            state_r        <= state_s;
            ocupado        <= (state_s != IDLE);
            entrada_pronta <= (state_s == CARGA_A) || (state_s == CARGA_B);
            saida_valida   <= (state_s == SAIDA);
            erro           <= (state_r == IDLE) && iniciar && !cmd_ok_s;
            if (state_r == IDLE && iniciar && cmd_ok_s) begin
                op_r <= operacao;
                n_r  <= tamanho;
            end
            if (step_s) begin
                row_r <= next_row_s;
                col_r <= next_col_s;
            end
            if (state_s == SAIDA) begin
                if (load_out_s) begin
                    saida_dado   <= out_val_s;
                    saida_ultimo <= next_last_s;
                end
            end else begin
                saida_dado   <= {RES_W{1'b0}};
                saida_ultimo <= 1'b0;
            end
`ifdef COPROC_MULT_MATRIZ_EN
            if (state_r == CALCULO && op_r == OP_MUL) begin
                if (kk_last_s) begin
                    kk_r  <= {TAM_W{1'b0}};
                    acc_r <= {RES_W{1'b0}};
                end else begin
                    kk_r  <= kk_r + TAM_W'(1);
                    acc_r <= res_s;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_coprocessador_matricial.sv
// Self-checking bench for coprocessador_matricial: directed vectors plus randomized commands
// checked against a plain-arithmetic matrix model.
module tb_coprocessador_matricial;
    localparam int DATA_W = 8;
    localparam int MAX_N  = 5;
    localparam int RES_W  = 2*DATA_W+3;
    localparam int TAM_W  = $clog2(MAX_N+1);
`ifdef COPROC_MULT_MATRIZ_EN
    localparam bit MULT_EN = 1'b1;
`else
    localparam bit MULT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset, iniciar, entrada_valida, entrada_pronta;
    logic [2:0]        operacao;
    logic [TAM_W-1:0]  tamanho;
    logic [DATA_W-1:0] entrada_dado;
    logic [RES_W-1:0]  saida_dado;
    logic              saida_valida, saida_pronta, saida_ultimo, ocupado, erro;

    int n_cmp  = 0;
    int n_fail = 0;
    int a_m [25];
    int b_m [25];
    int exp_r [25];
    int k_val;

    always #5 clk = ~clk;

    coprocessador_matricial #(.DATA_W(DATA_W), .MAX_N(MAX_N), .RES_W(RES_W)) dut (
        .clk(clk), .reset(reset), .iniciar(iniciar), .operacao(operacao), .tamanho(tamanho),
        .entrada_dado(entrada_dado), .entrada_valida(entrada_valida), .entrada_pronta(entrada_pronta),
        .saida_dado(saida_dado), .saida_valida(saida_valida), .saida_pronta(saida_pronta),
        .saida_ultimo(saida_ultimo), .ocupado(ocupado), .erro(erro)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: result matrix from the arithmetic definition of each opcode
    task automatic model(input int op, input int n);
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                int s;
                s = 0;
                case (op)
                    0: s = a_m[r*n+c] + b_m[r*n+c];
                    1: s = a_m[r*n+c] - b_m[r*n+c];
                    2: for (int k = 0; k < n; k++) s += a_m[r*n+k] * b_m[k*n+c];
                    3: s = a_m[r*n+c] * k_val;
                    4: s = -a_m[r*n+c];
                    5: s = a_m[c*n+r];
                    default: s = 0;
                endcase
                exp_r[r*n+c] = s;
            end
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_pronta"}, entrada_pronta, 0);
        chk({tag, "_valida"}, saida_valida, 0);
        chk({tag, "_ultimo"}, saida_ultimo, 0);
        chk({tag, "_ocupado"}, ocupado, 0);
        chk({tag, "_erro"}, erro, 0);
        chk({tag, "_dado"}, $signed(saida_dado), 0);
    endtask

    task automatic start_cmd(input int op, input int n);
        @(negedge clk);
        iniciar = 1'b1; operacao = 3'(op); tamanho = TAM_W'(n);
        @(negedge clk);
        iniciar = 1'b0;
        chk("start_ocupado", ocupado, 1);
        chk("start_erro", erro, 0);
    endtask

    task automatic bad_cmd(input int op, input int n);
        @(negedge clk);
        iniciar = 1'b1; operacao = 3'(op); tamanho = TAM_W'(n);
        @(negedge clk);
        iniciar = 1'b0;
        chk("bad_erro", erro, 1);
        chk("bad_ocupado", ocupado, 0);
        chk("bad_pronta", entrada_pronta, 0);
        @(negedge clk);
        chk("bad_erro_pulse", erro, 0);
        chk("bad_ocupado2", ocupado, 0);
    endtask

    task automatic load(input bit use_b, input int cnt);
        int i, guard;
        i = 0; guard = 0;
        while (i < cnt && guard < 500) begin
            if ($urandom_range(0, 3) == 0) begin
                entrada_valida = 1'b0;
                entrada_dado   = DATA_W'($urandom);
            end else begin
                entrada_valida = 1'b1;
                entrada_dado   = DATA_W'(use_b ? b_m[i] : a_m[i]);
                if (entrada_pronta) i++;
            end
            @(negedge clk);
            guard++;
        end
        chk("load_count", i, cnt);
    endtask

    // Measures CALCULO length while poking junk data and a bad command that must be ignored
    task automatic calc(input int exp_cycles);
        int c;
        bit saw_err;
        c = 0; saw_err = 1'b0;
        iniciar = 1'b1; operacao = 3'b111; tamanho = TAM_W'(0);
        while (!saida_valida && c < 300) begin
            if (erro) saw_err = 1'b1;
            c++;
            @(negedge clk);
        end
        iniciar = 1'b0; entrada_valida = 1'b0;
        chk("calc_cycles", c, exp_cycles);
        chk("busy_no_erro", saw_err, 0);
    endtask

    task automatic drain(input int n, input int stall, input int stop_at);
        int idx, cyc, nn;
        idx = 0; cyc = 0; nn = n*n;
        while (idx < stop_at && cyc < 400) begin
            chk("out_valida", saida_valida, 1);
            chk("out_dado", $signed(saida_dado), exp_r[idx]);
            chk("out_ultimo", saida_ultimo, (idx == nn-1));
            if (cyc < stall) saida_pronta = 1'b0;
            else             saida_pronta = ($urandom_range(0, 3) != 0);
            if (saida_pronta) idx++;
            @(negedge clk);
            cyc++;
        end
        saida_pronta = 1'b0;
        chk("out_count", idx, stop_at);
        if (stop_at == nn) begin
            chk("end_ocupado", ocupado, 0);
            chk("end_valida", saida_valida, 0);
        end
    endtask

    task automatic load_and_calc(input int op, input int n);
        int nn;
        nn = n*n;
        if (op == 3) b_m[0] = k_val;
        model(op, n);
        start_cmd(op, n);
        load(1'b0, nn);
        if (op <= 2)      load(1'b1, nn);
        else if (op == 3) load(1'b1, 1);
        entrada_valida = 1'b1;
        entrada_dado   = 8'hA5;
        chk("pronta_after_load", entrada_pronta, 0);
        calc((op == 2) ? nn*n : nn);
    endtask

    task automatic run(input int op, input int n, input int stall);
        load_and_calc(op, n);
        drain(n, stall, n*n);
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; operacao = 3'b000; tamanho = '0;
        entrada_dado = '0; entrada_valida = 1'b0; saida_pronta = 1'b0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        reset = 1'b0;

        a_m[0:3] = '{1, 2, 3, 4}; b_m[0:3] = '{10, 20, 30, 40};
        run(0, 2, 0);

        a_m[0:3] = '{-128, 0, 5, 127}; b_m[0:3] = '{127, 1, 5, -128};
        run(1, 2, 1);

        for (int i = 0; i < 9; i++) begin
            a_m[i] = i + 1;
            b_m[i] = (i % 4 == 0) ? 1 : 0;
        end
`ifdef COPROC_MULT_MATRIZ_EN
        run(2, 3, 0);
`else
        bad_cmd(2, 3);
`endif
        run(5, 3, 0);

        bad_cmd(0, 6);
        bad_cmd(7, 2);
        bad_cmd(6, 1);
        bad_cmd(0, 0);

        a_m[0:3] = '{7, -8, 127, -128};
        run(4, 2, 5);

        k_val = -128;
        a_m[0:3] = '{-128, 127, -1, 0};
        run(3, 2, 2);

        a_m[0:3] = '{1, 2, 3, 4}; b_m[0:3] = '{10, 20, 30, 40};
        load_and_calc(0, 2);
        drain(2, 0, 2);
        reset = 1'b1;
        @(negedge clk);
        chk_quiet("abort");
        iniciar = 1'b1; operacao = 3'b100; tamanho = TAM_W'(1);
        @(negedge clk);
        chk("reset_prio_ocupado", ocupado, 0);
        reset = 1'b0; iniciar = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_valida", saida_valida, 0);
            chk("abort_no_ocupado", ocupado, 0);
            @(negedge clk);
        end

        a_m[0] = -3;
        run(4, 1, 0);

        for (int t = 0; t < 12; t++) begin
            int op, n, v;
            op = $urandom_range(0, 5);
            n  = $urandom_range(1, MAX_N);
            for (int i = 0; i < 25; i++) begin
                v = $urandom_range(0, 255); a_m[i] = v - 128;
                v = $urandom_range(0, 255); b_m[i] = v - 128;
            end
            v = $urandom_range(0, 255); k_val = v - 128;
            if (op == 2 && !MULT_EN) bad_cmd(op, n);
            else                     run(op, n, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/coprocessador_matricial.md
COPROCESSADOR_MATRICIAL -- requirements
Module: coprocessador_matricial

Interface
REQ-001 Parameter DATA_W, default 8: element width, signed two's complement.
REQ-002 Parameter MAX_N, default 5: maximum matrix dimension; TAM_W = clog2(MAX_N+1).
REQ-003 Parameter RES_W, default 2*DATA_W+3: result element width.
REQ-004 clk  in  1: single clock, all logic on rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 iniciar  in  1: start pulse, sampled only in IDLE.
REQ-007 operacao  in  3: operation code, latched on accepted iniciar.
REQ-008 tamanho  in  TAM_W: matrix dimension N, latched on accepted iniciar.
REQ-009 entrada_dado  in  DATA_W: input element, row-major.
REQ-010 entrada_valida  in  1: entrada_dado valid.
REQ-011 entrada_pronta  out  1: block accepts input; transfer on entrada_valida&entrada_pronta.
REQ-012 saida_dado  out  RES_W: result element, row-major.
REQ-013 saida_valida  out  1: saida_dado valid.
REQ-014 saida_pronta  in  1: consumer accepts; transfer on saida_valida&saida_pronta.
REQ-015 saida_ultimo  out  1: high with the final (N*N-th) result element.
REQ-016 ocupado  out  1: high in every state except IDLE.
REQ-017 erro  out  1: one-cycle pulse on rejected command.

Function
REQ-018 Opcodes SHALL be: 000 A+B, 001 A-B, 010 A*B (matrix product), 011 A*k (scalar), 100 -A, 101 transpose(A); 110/111 invalid.
REQ-019 FSM states SHALL be IDLE, CARGA_A, CARGA_B, CALCULO, SAIDA.
REQ-020 IDLE + iniciar: if tamanho==0, tamanho>MAX_N or opcode invalid, pulse erro next cycle and stay IDLE; else latch operacao/tamanho, go CARGA_A.
REQ-021 CARGA_A SHALL accept exactly N*N elements into matrix A, then go CARGA_B for 000/001/010, CARGA_B for a single scalar k for 011, CALCULO otherwise.
REQ-022 CARGA_B SHALL accept N*N elements (one for 011), then go CALCULO.
REQ-023 entrada_pronta SHALL be high only in CARGA_A/CARGA_B; input while low is ignored.
REQ-024 CALCULO SHALL last N*N cycles for 000/001/011/100/101 and N*N*N cycles for 010 (one MAC per cycle), then go SAIDA.
REQ-025 Arithmetic SHALL sign-extend operands to RES_W; results exact for all DATA_W inputs, no saturation, no wrap for defaults.
REQ-026 Transpose: R[j][i] = A[i][j] sign-extended.
REQ-027 SAIDA SHALL present R[0][0]..R[N-1][N-1]; saida_valida high throughout SAIDA; index advances only on transfer; saida_dado/saida_valida held stable while saida_pronta low.
REQ-028 After the transfer with saida_ultimo high, go IDLE next cycle; ocupado low that cycle.
REQ-029 iniciar outside IDLE SHALL be ignored, no erro.
REQ-030 N=1 SHALL be legal: one element per phase, one CALCULO cycle.

Reset
REQ-031 reset SHALL force IDLE; entrada_pronta, saida_valida, saida_ultimo, ocupado, erro = 0; saida_dado = 0; counters = 0.
REQ-032 reset mid-operation SHALL abort without any further output transfer; matrix storage contents need not be cleared.
REQ-033 reset has priority over iniciar in the same cycle.

Configuration
REQ-034 Macro COPROC_MULT_MATRIZ_EN: defined -> opcode 010 supported per REQ-024; undefined -> 010 treated as invalid (erro pulse), no MAC/multiplier-accumulate logic for matrix product synthesised (scalar 011 unaffected).

Verification
REQ-035 N=2, op 000, A=[1,2,3,4], B=[10,20,30,40] -> outputs 11,22,33,44, saida_ultimo on 44.
REQ-036 N=2, op 001, A=[-128,0,5,127], B=[127,1,5,-128] -> -255,-1,0,255.
REQ-037 N=3, op 010, A=[1..9], B=identity -> outputs 1..9; CALCULO exactly 27 cycles (macro defined); macro undefined -> erro pulse, ocupado stays 0.
REQ-038 N=3, op 101, A=[1..9] -> 1,4,7,2,5,8,3,6,9; no CARGA_B phase (entrada_pronta low after 9th input).
REQ-039 tamanho=6 or op 111 with iniciar -> erro one cycle, ocupado 0; saida_pronta held low 5 cycles in SAIDA -> saida_dado unchanged, no element lost.
REQ-040 reset asserted mid-SAIDA after 2 transfers -> next cycle IDLE, all outputs 0; new N=1 op 100 A=[-3] -> single output 3 with saida_ultimo.
